// File: rtl/sbox_lane_scheduler.sv
// Shares one external 32-bit S-box lane between the round datapath (128-bit SubBytes,
// four lane passes) and key expansion (32-bit SubWord, one pass), one job at a time.
module sbox_lane_scheduler #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_req_data,
    output logic         st_rsp_valid,
    input  logic         st_rsp_ready,
    output logic [127:0] st_rsp_data,
    input  logic         key_req_valid,
    output logic         key_req_ready,
    input  logic [31:0]  key_req_data,
    output logic         key_rsp_valid,
    input  logic         key_rsp_ready,
    output logic [31:0]  key_rsp_data,
    output logic [31:0]  lane_in,
    input  logic [31:0]  lane_out
);

    typedef enum logic [2:0] {
        IDLE,
        S_RUN,
        K_RUN,
        S_OUT,
        K_OUT
    } state_t;

    typedef enum logic {
        GNT_STATE,
        GNT_KEY
    } grant_t;

    state_t       state;
    grant_t       last_grant;
    grant_t       grant;
    logic [1:0]   cnt;
    logic [127:0] st_op;
    logic [31:0]  key_op;

    // On a tie, round-robin hands the lane to whoever did not have it last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant = GNT_KEY;
        if (st_req_valid && key_req_valid) begin
            grant = (RR_EN && last_grant == GNT_KEY) ? GNT_STATE : GNT_KEY;
        end else if (st_req_valid) begin
            grant = GNT_STATE;
        end
    end

    assign st_req_ready  = (state == IDLE) && st_req_valid  && (grant == GNT_STATE);
    assign key_req_ready = (state == IDLE) && key_req_valid && (grant == GNT_KEY);

    // The lane is driven only while a pass is running, so it stays quiet when idle.
    always_comb begin
        lane_in = '0;
        case (state)
            S_RUN: begin
                case (cnt)
                    2'd0:    lane_in = st_op[127:96];
                    2'd1:    lane_in = st_op[95:64];
                    2'd2:    lane_in = st_op[63:32];
                    default: lane_in = st_op[31:0];
                endcase
            end
            K_RUN:   lane_in = key_op;
            default: lane_in = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and result registers are reset too, so an aborted job leaves nothing visible.
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= GNT_KEY;
            cnt           <= 2'd0;
            st_op         <= '0;
            key_op        <= '0;
            st_rsp_valid  <= 1'b0;
            st_rsp_data   <= '0;
            key_rsp_valid <= 1'b0;
            key_rsp_data  <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every read sees pre-edge values.
            case (state)
                IDLE: begin
                    if (st_req_ready) begin
                        st_op      <= st_req_data;
                        last_grant <= GNT_STATE;
                        cnt        <= 2'd0;
                        state      <= S_RUN;
                    end else if (key_req_ready) begin
                        key_op     <= key_req_data;
                        last_grant <= GNT_KEY;
                        state      <= K_RUN;
                    end
                end
                S_RUN: begin
                    case (cnt)
                        2'd0:    st_rsp_data[127:96] <= lane_out;
                        2'd1:    st_rsp_data[95:64]  <= lane_out;
                        2'd2:    st_rsp_data[63:32]  <= lane_out;
                        default: st_rsp_data[31:0]   <= lane_out;
                    endcase
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        st_rsp_valid <= 1'b1;
                        state        <= S_OUT;
                    end
                end
                K_RUN: begin
                    key_rsp_data  <= lane_out;
                    key_rsp_valid <= 1'b1;
                    state         <= K_OUT;
                end
                S_OUT: begin
                    if (st_rsp_ready) begin
                        st_rsp_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                K_OUT: begin
                    if (key_rsp_ready) begin
                        key_rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_lane_scheduler.sv
// Directed bench for sbox_lane_scheduler: an AES S-box model drives the lane, a scoreboard
// holds expected results, and two instances cover round-robin and key-priority arbitration.
module tb_sbox_lane_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         a_st_req_valid, a_st_req_ready, a_st_rsp_valid, a_st_rsp_ready;
    logic [127:0] a_st_req_data, a_st_rsp_data;
    logic         a_key_req_valid, a_key_req_ready, a_key_rsp_valid, a_key_rsp_ready;
    logic [31:0]  a_key_req_data, a_key_rsp_data, a_lane_in, a_lane_out;

    logic         b_st_req_valid, b_st_req_ready, b_st_rsp_valid, b_st_rsp_ready;
    logic [127:0] b_st_req_data, b_st_rsp_data;
    logic         b_key_req_valid, b_key_req_ready, b_key_rsp_valid, b_key_rsp_ready;
    logic [31:0]  b_key_req_data, b_key_rsp_data, b_lane_in, b_lane_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // Inverse as a^254 (= a^2 * a^4 * ... * a^128), then the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x = a;
        logic [7:0] inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            x   = gmul(x, x);
            inv = gmul(inv, x);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    assign a_lane_out = sub_word(a_lane_in);
    assign b_lane_out = sub_word(b_lane_in);

    sbox_lane_scheduler #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_req_valid(a_st_req_valid), .st_req_ready(a_st_req_ready), .st_req_data(a_st_req_data),
        .st_rsp_valid(a_st_rsp_valid), .st_rsp_ready(a_st_rsp_ready), .st_rsp_data(a_st_rsp_data),
        .key_req_valid(a_key_req_valid), .key_req_ready(a_key_req_ready), .key_req_data(a_key_req_data),
        .key_rsp_valid(a_key_rsp_valid), .key_rsp_ready(a_key_rsp_ready), .key_rsp_data(a_key_rsp_data),
        .lane_in(a_lane_in), .lane_out(a_lane_out)
    );

    sbox_lane_scheduler #(.RR_EN(1'b0)) dut_kp (
        .clk(clk), .rst_n(rst_n),
        .st_req_valid(b_st_req_valid), .st_req_ready(b_st_req_ready), .st_req_data(b_st_req_data),
        .st_rsp_valid(b_st_rsp_valid), .st_rsp_ready(b_st_rsp_ready), .st_rsp_data(b_st_rsp_data),
        .key_req_valid(b_key_req_valid), .key_req_ready(b_key_req_ready), .key_req_data(b_key_req_data),
        .key_rsp_valid(b_key_rsp_valid), .key_rsp_ready(b_key_rsp_ready), .key_rsp_data(b_key_rsp_data),
        .lane_in(b_lane_in), .lane_out(b_lane_out)
    );

    int vectors = 0;
    int miscompares = 0;
    int t_acc_st, t_acc_key;
    logic [127:0] sb_st[$];
    logic [31:0]  sb_key[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic accept_st(input logic [127:0] d, input logic [127:0] exp);
        int n = 0;
        a_st_req_valid = 1'b1;
        a_st_req_data  = d;
        #1;
        while (!a_st_req_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("st_accept", 128'(a_st_req_ready), 128'(1));
        t_acc_st = cyc;
        sb_st.push_back(exp);
        @(negedge clk);
        a_st_req_valid = 1'b0;
        a_st_req_data  = ~d;
    endtask

    task automatic accept_key(input logic [31:0] d, input logic [31:0] exp);
        int n = 0;
        a_key_req_valid = 1'b1;
        a_key_req_data  = d;
        #1;
        while (!a_key_req_ready && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("key_accept", 128'(a_key_req_ready), 128'(1));
        t_acc_key = cyc;
        sb_key.push_back(exp);
        @(negedge clk);
        a_key_req_valid = 1'b0;
        a_key_req_data  = ~d;
    endtask

    task automatic expect_st(input int lat, input bit early_ready, input int hold);
        int n = 0;
        bit stable = 1'b1;
        logic [127:0] exp;
        if (early_ready) a_st_rsp_ready = 1'b1;
        while (!a_st_rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("st_rsp_latency", 128'(cyc - t_acc_st), 128'(lat));
        exp = (sb_st.size() != 0) ? sb_st.pop_front() : 'x;
        check("st_rsp_data", a_st_rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            if (a_st_rsp_valid !== 1'b1 || a_st_rsp_data !== exp || a_st_req_ready || a_key_req_ready)
                stable = 1'b0;
        end
        if (hold > 0) check("st_hold_stable", 128'(stable), 128'(1));
        a_st_rsp_ready = 1'b1;
        @(negedge clk);
        a_st_rsp_ready = 1'b0;
        check("st_rsp_drop", 128'(a_st_rsp_valid), 128'(0));
    endtask

    task automatic expect_key(input int lat);
        int n = 0;
        bit st_quiet = 1'b1;
        logic [31:0] exp;
        while (!a_key_rsp_valid && n < 30) begin
            if (a_st_req_ready) st_quiet = 1'b0;
            @(negedge clk);
            n++;
        end
        if (a_st_req_ready) st_quiet = 1'b0;
        check("key_rsp_latency", 128'(cyc - t_acc_key), 128'(lat));
        exp = (sb_key.size() != 0) ? sb_key.pop_front() : 'x;
        check("key_rsp_data", 128'(a_key_rsp_data), 128'(exp));
        check("key_job_st_ready_low", 128'(st_quiet), 128'(1));
        a_key_rsp_ready = 1'b1;
        @(negedge clk);
        a_key_rsp_ready = 1'b0;
        check("key_rsp_drop", 128'(a_key_rsp_valid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        logic [31:0]  k;
        logic [31:0]  kexp;
        bit           seen;

        rst_n = 1'b0;
        a_st_req_valid = 1'b0; a_st_req_data = '0; a_st_rsp_ready = 1'b0;
        a_key_req_valid = 1'b0; a_key_req_data = '0; a_key_rsp_ready = 1'b0;
        b_st_req_valid = 1'b0; b_st_req_data = '0; b_st_rsp_ready = 1'b0;
        b_key_req_valid = 1'b0; b_key_req_data = '0; b_key_rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {a_st_rsp_data[95:0], a_key_rsp_data},
              {96'h0, 32'h0});
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_flags", 128'({a_st_req_ready, a_key_req_ready, a_st_rsp_valid, a_key_rsp_valid,
                                  b_st_rsp_valid, b_key_rsp_valid}), 128'(0));
        check("idle_lane_in", 128'(a_lane_in), 128'(0));

        // Tie straight out of reset: state wins first, then key, then state again.
        d = {$urandom, $urandom, $urandom, $urandom};
        k = $urandom;
        a_st_req_valid = 1'b1; a_st_req_data = d;
        a_key_req_valid = 1'b1; a_key_req_data = k;
        #1;
        check("tie1_grant", 128'({a_st_req_ready, a_key_req_ready}), 128'(2'b10));
        accept_st(d, sub_state(d));
        #1;
        check("busy_key_ready_low", 128'(a_key_req_ready), 128'(0));
        expect_st(5, 1'b0, 0);
        accept_key(k, sub_word(k));
        expect_key(2);
        d = {$urandom, $urandom, $urandom, $urandom};
        a_st_req_valid = 1'b1; a_st_req_data = d;
        a_key_req_valid = 1'b1; a_key_req_data = k;
        #1;
        check("tie2_grant", 128'({a_st_req_ready, a_key_req_ready}), 128'(2'b10));
        accept_st(d, sub_state(d));
        a_key_req_valid = 1'b0;
        expect_st(5, 1'b0, 0);

        // FIPS-197 first-round SubBytes vector; rsp_ready held high before valid must be ignored.
        accept_st(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
        expect_st(5, 1'b1, 0);

        // SubWord of 09cf4f3c byte-for-byte: 09->01, cf->8a, 4f->84, 3c->eb.
        accept_key(32'h09cf4f3c, 32'h018a84eb);
        expect_key(2);

        // Consumer stalls for 10 cycles while a key request waits.
        d = {$urandom, $urandom, $urandom, $urandom};
        accept_st(d, sub_state(d));
        k = $urandom;
        a_key_req_valid = 1'b1; a_key_req_data = k;
        expect_st(5, 1'b0, 10);
        accept_key(k, sub_word(k));
        expect_key(2);

        // Reset in the middle of a state job, with the lane on word 2.
        d = {$urandom, $urandom, $urandom, $urandom};
        accept_st(d, sub_state(d));
        @(negedge clk);
        @(negedge clk);
        check("s_run_lane_word2", 128'(a_lane_in), 128'(d[63:32]));
        rst_n = 1'b0;
        #1;
        check("midjob_reset_outputs",
              {a_st_rsp_data[127:32], a_lane_in},
              {96'h0, 32'h0});
        check("midjob_reset_flags", 128'({a_st_req_ready, a_key_req_ready, a_st_rsp_valid,
                                          a_key_rsp_valid, a_key_rsp_data}), 128'(0));
        sb_st.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (a_st_rsp_valid !== 1'b0 || a_lane_in !== 32'h0) seen = 1'b1;
        end
        check("dropped_job_silent", 128'(seen), 128'(0));

        // Key-priority instance: key wins three ties in a row, state waits.
        d = {$urandom, $urandom, $urandom, $urandom};
        b_st_req_valid = 1'b1; b_st_req_data = d;
        b_key_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_key_req_data = $urandom;
            #1;
            check("kp_tie_grant", 128'({b_st_req_ready, b_key_req_ready}), 128'(2'b01));
            sb_key.push_back(sub_word(b_key_req_data));
            @(negedge clk);
            b_key_req_data = ~b_key_req_data;
            seen = 1'b0;
            for (int n = 0; n < 10 && !b_key_rsp_valid; n++) @(negedge clk);
            kexp = (sb_key.size() != 0) ? sb_key.pop_front() : 'x;
            check("kp_key_rsp", 128'({b_key_rsp_valid, b_key_rsp_data}), 128'({1'b1, kexp}));
            b_key_rsp_ready = 1'b1;
            @(negedge clk);
            b_key_rsp_ready = 1'b0;
        end
        b_key_req_valid = 1'b0;
        #1;
        check("kp_state_after", 128'(b_st_req_ready), 128'(1));
        sb_st.push_back(sub_state(d));
        @(negedge clk);
        b_st_req_valid = 1'b0;
        for (int n = 0; n < 10 && !b_st_rsp_valid; n++) @(negedge clk);
        check("kp_st_rsp_valid", 128'(b_st_rsp_valid), 128'(1));
        check("kp_st_rsp_data", b_st_rsp_data, (sb_st.size() != 0) ? sb_st.pop_front() : 'x);
        b_st_rsp_ready = 1'b1;
        @(negedge clk);
        b_st_rsp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
